// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmitter.
//   - uart_state_e       : transmitter FSM states
//   - UART_DATA_BITS     : data bits per frame (8N1)
//   - UART_TX_FIFO_DEPTH : entries in the optional transmit FIFO
//   - uart_clks_per_bit  : system clocks per serial bit (truncating divide)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS     = 8;
    localparam int unsigned UART_TX_FIFO_DEPTH = 4;

    function automatic int unsigned uart_clks_per_bit(input int unsigned clk_freq_hz,
                                                      input int unsigned baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Small synchronous FIFO with show-ahead read data (rdata_o is the head
//   entry whenever empty_o is low). Pushing while full is honoured only when
//   a pop happens in the same cycle; popping while empty is ignored.
//
//   Ports:
//     clk_i    in   clock, rising edge
//     rst_ni   in   asynchronous active-low reset; empties the FIFO
//     push_i   in   write wdata_i this cycle
//     wdata_i  in   WIDTH-bit write data
//     pop_i    in   drop the head entry this cycle
//     rdata_o  out  head entry
//     full_o   out  DEPTH entries held
//     empty_o  out  no entries held
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   8N1 UART transmitter driving the TXD pin at CLK_FREQ_HZ / BAUD_RATE
//   clocks per bit.
//
//   Optional build macro: UART_TX_FIFO_EN
//     defined     : a UART_TX_FIFO_DEPTH-entry FIFO buffers accepted bytes,
//                   tx_ready = !fifo_full, busy also covers pending bytes.
//     not defined : the byte goes straight into the shift register,
//                   tx_ready = (state == IDLE).
//
//   Handshake: a byte on tx_data is taken at a rising clk edge where
//   tx_valid && tx_ready; tx_data is ignored at any other time, and
//   tx_valid may stay high for as long as the producer likes.
//
//   Ports:
//     clk        in   system clock, rising edge
//     reset      in   asynchronous active-low reset (aborts any frame)
//     tx_data    in   byte to send
//     tx_valid   in   producer offers tx_data
//     tx_ready   out  a byte can be accepted this cycle
//     txd        out  serial line, idle high, registered
//     busy       out  frame in progress or bytes pending
//     dbg_state  out  current FSM state (uart_state_e encoding)
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12_000_000,
    parameter int unsigned BAUD_RATE   = 115_200
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      txd,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam int unsigned CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int unsigned BIT_IDX_W    = $clog2(UART_DATA_BITS);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(UART_DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_state_e               state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic [BIT_IDX_W-1:0]      bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      txd_q;
    logic                      bit_end;
    logic                      load;
    logic [UART_DATA_BITS-1:0] load_data;

    assign bit_end   = (cnt_q == CNT_LAST);
    assign cnt_d     = cnt_q + 1'b1;
    assign txd       = txd_q;
    assign dbg_state = state_q;

`ifdef UART_TX_FIFO_EN
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rdata;

    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign load      = fifo_pop;
    assign load_data = fifo_rdata;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (UART_TX_FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (fifo_push),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
`else
    assign tx_ready  = (state_q == ST_IDLE);
    assign load      = tx_valid && tx_ready;
    assign load_data = tx_data;
    assign busy      = (state_q != ST_IDLE);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            // The line level is registered from the current state, so txd
            // trails the state by one cycle: the start bit appears on the
            // edge after the byte is loaded and every level is still exactly
            // CLKS_PER_BIT cycles long.
            case (state_q)
                ST_START: txd_q <= 1'b0;
                ST_DATA:  txd_q <= shift_q[0];
                default:  txd_q <= 1'b1;
            endcase

            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        shift_q   <= load_data;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == BIT_LAST) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//   Directed bench for uart_tx at 12 MHz / 1 Mbaud (12 clocks per bit).
//   Inputs change and outputs are sampled 1 ns after each rising edge.
//   Sample index k counts edges after the accepting edge N (k=0 is just
//   after N). Without the FIFO the start bit occupies k=1..12; with the FIFO
//   the pop costs one extra cycle (LAT).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned CLK_HZ = 12_000_000;
    localparam int unsigned BAUD   = 1_000_000;
    localparam int          CPB    = 12;
    localparam int          FRAME  = 10 * CPB;
`ifdef UART_TX_FIFO_EN
    localparam int          LAT    = 1;
`else
    localparam int          LAT    = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         frame_err = 0;
    bit         mon_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .txd       (txd),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- model helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Level of bit j (0 = start, 1..8 = data LSB first, 9 = stop) of a frame.
    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return d[j-1];
    endfunction

    // Serial decoder: samples each bit mid-way from the first low sample.
    initial begin : decoder
        logic [7:0] sh;
        sh = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && reset === 1'b1 && txd === 1'b0) begin
                repeat (CPB / 2 - 1) begin @(posedge clk); #1; end
                if (txd !== 1'b0) frame_err++;
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) begin @(posedge clk); #1; end
                    sh[b] = txd;
                end
                repeat (CPB) begin @(posedge clk); #1; end
                if (txd !== 1'b1) frame_err++;
                rx_q.push_back(sh);
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        total++;
        if ({txd, tx_ready, busy} !== 3'b110) begin
            bad++;
            $display("FAIL reset_hold: txd/ready/busy=%b expected 110", {txd, tx_ready, busy});
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: state=%0d expected 0", dbg_state);
        end
        reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            total++;
            if ({txd, tx_ready, busy} !== 3'b110) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: txd/ready/busy=%b expected 110", i, {txd, tx_ready, busy});
            end
        end
    endtask

    task automatic test_send_55();
        int  bcnt;
        logic exp;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();                       // edge N accepts 0x55
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        total++;
        if (txd !== 1'b1) begin
            bad++;
            $display("FAIL send55_latency: txd=%b expected 1 right after accept", txd);
        end
        bcnt = (busy === 1'b1) ? 1 : 0;
        for (int k = 1; k <= FRAME + LAT; k++) begin
            tick();
            exp = (k <= LAT) ? 1'b1 : frame_bit(8'h55, (k - 1 - LAT) / CPB);
            total++;
            if (txd !== exp) begin
                bad++;
                $display("FAIL send55_txd k=%0d: txd=%b expected %b", k, txd, exp);
            end
            if (busy === 1'b1) bcnt++;
        end
        total++;
        if (bcnt != FRAME + LAT) begin
            bad++;
            $display("FAIL send55_busy_len: busy high %0d cycles expected %0d", bcnt, FRAME + LAT);
        end
        tick();
        total++;
        if ({txd, busy} !== 2'b10) begin
            bad++;
            $display("FAIL send55_end: txd/busy=%b expected 10", {txd, busy});
        end
    endtask

`ifndef UART_TX_FIFO_EN
    task automatic test_back_to_back();
        logic exp;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();                       // edge N accepts 0x00
        tx_data  = 8'hFF;             // tx_valid stays high
        total++;
        if (tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready k=0: ready=%b expected 0", tx_ready);
        end
        for (int k = 1; k <= 2 * FRAME + 1; k++) begin
            tick();
            if (k <= FRAME + 1) begin
                total++;
                if (tx_ready !== (k == FRAME)) begin
                    bad++;
                    $display("FAIL b2b_ready k=%0d: ready=%b expected %b", k, tx_ready, (k == FRAME));
                end
            end
            if (k <= FRAME)          exp = frame_bit(8'h00, (k - 1) / CPB);
            else if (k == FRAME + 1) exp = 1'b1;
            else                     exp = frame_bit(8'hFF, (k - FRAME - 2) / CPB);
            total++;
            if (txd !== exp) begin
                bad++;
                $display("FAIL b2b_txd k=%0d: txd=%b expected %b", k, txd, exp);
            end
            if (k == FRAME + 1) tx_valid = 1'b0;   // 0xFF taken at this edge
        end
        tick();
        total++;
        if ({txd, busy} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_end: txd/busy=%b expected 10", {txd, busy});
        end
    endtask
`endif

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo();
        int  acc_cyc[5];
        int  n;
        int  bcnt;
        bit  started;
        bit  acc;
        logic [7:0] e;
        logic [7:0] r;
        exp_q.delete();
        rx_q.delete();
        frame_err = 0;
        mon_en    = 1'b1;
        n = 0; bcnt = 0; started = 1'b0;
        for (int i = 0; i < 5; i++) acc_cyc[i] = -1;
        tx_data  = 8'h41;
        tx_valid = 1'b1;
        for (int w = 0; w < 2000; w++) begin
            acc = tx_valid && tx_ready;
            tick();
            if (acc) begin
                exp_q.push_back(tx_data);
                acc_cyc[n] = w;
                n++;
                started = 1'b1;
                if (n == 5) tx_valid = 1'b0;
                else        tx_data  = 8'(8'h41 + n);
            end
            if (started) begin
                if (busy === 1'b1) bcnt++;
                else break;
            end
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (acc_cyc[i] != i) begin
                bad++;
                $display("FAIL fifo_accept byte %0d: accepted at cycle %0d expected %0d", i, acc_cyc[i], i);
            end
        end
        total++;
        if (bcnt != 5 * (FRAME + 1)) begin
            bad++;
            $display("FAIL fifo_busy_len: busy high %0d cycles expected %0d", bcnt, 5 * (FRAME + 1));
        end
        total++;
        if (rx_q.size() != 5) begin
            bad++;
            $display("FAIL fifo_count: decoded %0d frames expected 5", rx_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            total++;
            if (r !== e) begin
                bad++;
                $display("FAIL fifo_order: got %h expected %h", r, e);
            end
        end
        total++;
        if (frame_err != 0) begin
            bad++;
            $display("FAIL fifo_framing: %0d framing errors expected 0", frame_err);
        end
        mon_en = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_frame();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();                       // edge N accepts 0xA5
        tx_valid = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            // With the FIFO, queue two more bytes that reset must discard.
            if (LAT == 1 && k == 1) begin tx_data = 8'h11; tx_valid = 1'b1; end
            if (LAT == 1 && k == 2) begin tx_data = 8'h22; tx_valid = 1'b1; end
            if (k == 3) tx_valid = 1'b0;
        end
        // k=50 lies in frame bit 4 = data bit 3 of 0xA5, which is 0.
        total++;
        if (txd !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_pre: txd=%b expected 0", txd);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({txd, tx_ready, busy} !== 3'b110) begin
            bad++;
            $display("FAIL rst_mid_async: txd/ready/busy=%b expected 110", {txd, tx_ready, busy});
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL rst_mid_state: state=%0d expected 0", dbg_state);
        end
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tick();
            total++;
            if ({txd, busy} !== 2'b10) begin
                bad++;
                $display("FAIL rst_no_resume cycle %0d: txd/busy=%b expected 10", i, {txd, busy});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        logic [7:0] r;
        bit acc;
        bit timed_out;
        exp_q.delete();
        rx_q.delete();
        frame_err = 0;
        mon_en    = 1'b1;
        timed_out = 1'b0;
        for (int n = 0; n < 256 && !timed_out; n++) begin
            tx_data  = 8'($urandom_range(0, 255));
            tx_valid = 1'b1;
            acc = 1'b0;
            for (int w = 0; w < 500 && !acc; w++) begin
                acc = tx_ready;
                tick();
            end
            if (!acc) timed_out = 1'b1;
            else      exp_q.push_back(tx_data);
        end
        tx_valid = 1'b0;
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL rand_accept: byte %0d not accepted within 500 cycles", exp_q.size());
        end
        for (int w = 0; w < 3000 && rx_q.size() < exp_q.size(); w++) tick();
        total++;
        if (rx_q.size() != 256) begin
            bad++;
            $display("FAIL rand_count: decoded %0d frames expected 256", rx_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            total++;
            if (r !== e) begin
                bad++;
                $display("FAIL rand_byte: got %h expected %h", r, e);
            end
        end
        total++;
        if (frame_err != 0) begin
            bad++;
            $display("FAIL rand_framing: %0d framing errors expected 0", frame_err);
        end
        mon_en = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_send_55();
        repeat (5) tick();
`ifndef UART_TX_FIFO_EN
        test_back_to_back();
`else
        test_fifo();
`endif
        repeat (5) tick();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
